// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between port A (CPU core,
// primary) and port B (host loader / debug). A has fixed priority. A
// starvation counter forces one B access after MAX_HOLD consecutive A
// grants while B waits. Each read is tagged with its requester, and the
// matching rvalid is raised on the following cycle, when the RAM data
// arrives.
//
// Handshake (req/gnt): a requester raises req together with we/addr/wdata
// and holds them stable until it sees gnt. gnt is combinational and marks
// the cycle the access is performed. There is no queue, so req may drop
// without a grant and nothing is remembered. A read that was granted in
// cycle N returns ram_rdata together with rvalid=1 in cycle N+1.
module ram_port_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [7:0]        hold_cnt
);

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    logic [7:0] hold_q;
    logic       gnt_a;
    logic       gnt_b;
    logic       rvalid_a_q;
    logic       rvalid_b_q;

    // Grant decision: B wins only when A is idle or A has used up its hold budget.
    // Both grants are held low while rst is asserted.
    always_comb begin
        gnt_b = 1'b0;
        gnt_a = 1'b0;
        if (!rst) begin
            gnt_b = b_req & (~a_req | (hold_q == HOLD_MAX));
            gnt_a = a_req & ~gnt_b;
        end
    end

    // RAM mux: the granted port drives the RAM; with no grant everything is zero.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt_a) begin
            ram_we    = a_we;
            ram_addr  = a_addr;
            ram_wdata = a_wdata;
        end else if (gnt_b) begin
            ram_we    = b_we;
            ram_addr  = b_addr;
            ram_wdata = b_wdata;
        end
    end

    // Starvation counter: counts A grants taken while B waits, cleared once B is served or gives up.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= 8'd0;
        end else if (gnt_a && b_req) begin
            if (hold_q != HOLD_MAX) begin
                hold_q <= hold_q + 8'd1;
            end
        end else if (gnt_b || !b_req) begin
            hold_q <= 8'd0;
        end
    end

    // Read tags: a granted read raises its requester's rvalid for exactly the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            rvalid_a_q <= gnt_a & ~a_we;
            rvalid_b_q <= gnt_b & ~b_we;
        end
    end

    assign a_gnt    = gnt_a;
    assign b_gnt    = gnt_b;
    assign a_rvalid = rvalid_a_q;
    assign b_rvalid = rvalid_b_q;
    assign a_rdata  = ram_rdata;
    assign b_rdata  = ram_rdata;
    assign hold_cnt = hold_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: two arbiters (MAX_HOLD=8 and MAX_HOLD=1) share the
// same requester inputs. The main instance drives a RAM model in the bench.
// A behavioural reference, made of a streak count and a shadow memory,
// predicts grants, RAM outputs, hold count, rvalid and read data on every
// cycle. Directed sequences pin the reference with literal expectations.
module tb_ram_port_arbiter;

    localparam int AW = 13;
    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;

    logic          a_gnt, a_rvalid, b_gnt, b_rvalid, ram_we;
    logic [DW-1:0] a_rdata, b_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
    logic [7:0]    hold_cnt;

    logic          d1_a_gnt, d1_a_rvalid, d1_b_gnt, d1_b_rvalid, d1_ram_we;
    logic [DW-1:0] d1_a_rdata, d1_b_rdata, d1_ram_wdata;
    logic [DW-1:0] d1_ram_rdata;
    logic [AW-1:0] d1_ram_addr;
    logic [7:0]    d1_hold_cnt;

    logic [DW-1:0] ram   [0:(1<<AW)-1];
    logic [DW-1:0] mem_m [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    // reference model state
    int            st8, st1;
    logic          model_ok;
    logic          m_arv, m_brv, m1_arv, m1_brv;
    logic [DW-1:0] m_adata, m_bdata;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(8)) u_dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .hold_cnt(hold_cnt)
    );

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(d1_a_gnt), .a_rvalid(d1_a_rvalid), .a_rdata(d1_a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(d1_b_gnt), .b_rvalid(d1_b_rvalid), .b_rdata(d1_b_rdata),
        .ram_we(d1_ram_we), .ram_addr(d1_ram_addr), .ram_wdata(d1_ram_wdata),
        .ram_rdata(d1_ram_rdata), .hold_cnt(d1_hold_cnt)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign d1_ram_rdata = '0;

    // RAM environment: one-cycle read latency
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        else        ram_rdata     <= ram[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void arb(input logic ar, input logic br, input int streak, input int maxh,
                                output logic ag, output logic bg);
        bg = br && (!ar || streak == maxh);
        ag = ar && !bg;
    endfunction

    function automatic int next_streak(input logic ag, input logic br, input int streak, input int maxh);
        if (ag && br) return (streak + 1 > maxh) ? maxh : streak + 1;
        return 0;
    endfunction

    // compare process: every cycle, compare against the reference, then advance it
    always @(negedge clk) begin : compare
        logic          ag, bg, ag1, bg1, ewe;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] ewd;
        ag = 1'b0; bg = 1'b0; ag1 = 1'b0; bg1 = 1'b0;
        if (!rst) begin
            arb(a_req, b_req, st8, 8, ag, bg);
            arb(a_req, b_req, st1, 1, ag1, bg1);
        end
        ewe = 1'b0; eaddr = '0; ewd = '0;
        if (ag) begin
            ewe = a_we; eaddr = a_addr; ewd = a_wdata;
        end else if (bg) begin
            ewe = b_we; eaddr = b_addr; ewd = b_wdata;
        end
        chk("a_gnt", 32'(a_gnt), 32'(ag));
        chk("b_gnt", 32'(b_gnt), 32'(bg));
        chk("ram_we", 32'(ram_we), 32'(ewe));
        chk("ram_addr", 32'(ram_addr), 32'(eaddr));
        chk("ram_wdata", 32'(ram_wdata), 32'(ewd));
        chk("d1_a_gnt", 32'(d1_a_gnt), 32'(ag1));
        chk("d1_b_gnt", 32'(d1_b_gnt), 32'(bg1));
        if (model_ok) begin
            chk("hold_cnt", 32'(hold_cnt), 32'(st8));
            chk("a_rvalid", 32'(a_rvalid), 32'(m_arv));
            chk("b_rvalid", 32'(b_rvalid), 32'(m_brv));
            if (m_arv) chk("a_rdata", 32'(a_rdata), 32'(m_adata));
            if (m_brv) chk("b_rdata", 32'(b_rdata), 32'(m_bdata));
            chk("d1_hold_cnt", 32'(d1_hold_cnt), 32'(st1));
            chk("d1_a_rvalid", 32'(d1_a_rvalid), 32'(m1_arv));
            chk("d1_b_rvalid", 32'(d1_b_rvalid), 32'(m1_brv));
        end
        if (rst) begin
            st8 = 0; st1 = 0;
            m_arv = 1'b0; m_brv = 1'b0; m1_arv = 1'b0; m1_brv = 1'b0;
            model_ok = 1'b1;
        end else begin
            m_arv = ag && !a_we;
            m_brv = bg && !b_we;
            if (m_arv) m_adata = mem_m[a_addr];
            if (m_brv) m_bdata = mem_m[b_addr];
            if (ag && a_we) mem_m[a_addr] = a_wdata;
            if (bg && b_we) mem_m[b_addr] = b_wdata;
            m1_arv = ag1 && !a_we;
            m1_brv = bg1 && !b_we;
            st8 = next_streak(ag, b_req, st8, 8);
            st1 = next_streak(ag1, b_req, st1, 1);
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_a(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0);
    endtask

    initial begin : stimulus
        logic [DW-1:0] b_exp [0:3];
        model_ok = 1'b0;
        st8 = 0; st1 = 0;
        m_arv = 1'b0; m_brv = 1'b0; m1_arv = 1'b0; m1_brv = 1'b0;
        m_adata = '0; m_bdata = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]   = 16'(i) ^ 16'hA5A5;
            mem_m[i] = 16'(i) ^ 16'hA5A5;
        end
        ram_rdata = '0;
        b_exp[0] = 16'hA5A5; b_exp[1] = 16'hA5A4; b_exp[2] = 16'hA5A7; b_exp[3] = 16'hA5A6;

        // reset with requests active: no grants, RAM outputs zero
        rst = 1'b1;
        idle();
        set_a(1'b1, 1'b1, 13'h055, 16'hBEEF);
        set_b(1'b1, 1'b0, 13'h066, '0);
        mid();
        chk("rst_a_gnt", 32'(a_gnt), 32'd0);
        chk("rst_b_gnt", 32'(b_gnt), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        step();
        idle();
        step(); step();
        rst = 1'b0;

        // reset mid-read
        set_a(1'b1, 1'b0, 13'h004, '0);
        mid();
        chk("mr_a_gnt", 32'(a_gnt), 32'd1);
        step();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
        mid();
        chk("mr_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("mr_hold_cnt", 32'(hold_cnt), 32'd0);
        chk("mr_ram_we", 32'(ram_we), 32'd0);
        chk("mr_ram_addr", 32'(ram_addr), 32'd0);
        chk("mr_ram_wdata", 32'(ram_wdata), 32'd0);
        step();

        // solo A: write then read back
        set_a(1'b1, 1'b1, 13'h3E8, 16'h1234);
        mid();
        chk("sa_w_gnt", 32'(a_gnt), 32'd1);
        chk("sa_w_we", 32'(ram_we), 32'd1);
        step();
        set_a(1'b1, 1'b0, 13'h3E8, '0);
        mid();
        chk("sa_r_gnt", 32'(a_gnt), 32'd1);
        chk("sa_r_we", 32'(ram_we), 32'd0);
        chk("sa_r_rvalid_early", 32'(a_rvalid), 32'd0);
        step();
        idle();
        mid();
        chk("sa_rvalid", 32'(a_rvalid), 32'd1);
        chk("sa_rdata", 32'(a_rdata), 32'h1234);
        step();

        // solo B: four back-to-back reads
        for (int k = 0; k < 5; k++) begin
            if (k < 4) set_b(1'b1, 1'b0, 13'(k), '0);
            else       idle();
            mid();
            if (k < 4) chk("sb_gnt", 32'(b_gnt), 32'd1);
            if (k >= 1) begin
                chk("sb_rvalid", 32'(b_rvalid), 32'd1);
                chk("sb_rdata", 32'(b_rdata), 32'(b_exp[k-1]));
            end else begin
                chk("sb_rvalid0", 32'(b_rvalid), 32'd0);
            end
            step();
        end

        // same-address contention: A write wins, B reads the new value next
        set_a(1'b1, 1'b1, 13'h010, 16'h00FF);
        set_b(1'b1, 1'b0, 13'h010, '0);
        mid();
        chk("sc_a_gnt", 32'(a_gnt), 32'd1);
        chk("sc_b_gnt0", 32'(b_gnt), 32'd0);
        step();
        set_a(1'b0, 1'b0, '0, '0);
        mid();
        chk("sc_b_gnt1", 32'(b_gnt), 32'd1);
        step();
        idle();
        mid();
        chk("sc_b_rvalid", 32'(b_rvalid), 32'd1);
        chk("sc_b_rdata", 32'(b_rdata), 32'h00FF);
        step();

        // starvation: both request continuously
        for (int k = 0; k < 18; k++) begin
            set_a(1'b1, 1'b0, 13'(13'h100 + k), '0);
            set_b(1'b1, 1'b0, 13'h020, '0);
            mid();
            chk("st_hold", 32'(hold_cnt), 32'(k % 9));
            chk("st_b_gnt", 32'(b_gnt), 32'((k % 9) == 8));
            chk("st1_hold", 32'(d1_hold_cnt), 32'(k % 2));
            chk("st1_b_gnt", 32'(d1_b_gnt), 32'((k % 2) == 1));
            chk("st1_excl", 32'(d1_a_gnt ^ d1_b_gnt), 32'd1);
            step();
        end
        idle();
        step();

        // randomized traffic, including occasional resets
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            set_a($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  13'($urandom_range(0, 15)), 16'($urandom));
            set_b($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                  13'($urandom_range(0, 15)), 16'($urandom));
            step();
        end
        rst = 1'b0;
        idle();
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
